alu_sequencer: RTL and testbench

Multi-cycle control and datapath sequencer that drives the ALU's command side and consumes its results. Accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it into `ALUOp`, `func`, `in1` and `in2`. Samples `ALUOut` and `zeroFlag` and performs write-back or branch resolution. It owns the 32×32 register file and the PC, and sits between instruction fetch and the ALU.

---
 rtl/alu_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle instruction sequencer: decodes one instruction at a time, drives the ALU,
// and retires it by writing the register file or resolving a branch.
module alu_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [1:0]  alu_op,
    output logic [5:0]  alu_func,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic [31:0] pc,
    output logic        done,
    output logic        err,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [1:0]  dbg_state
);

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only while IDLE.
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    state_t      r_state;
    logic [31:0] r_instr;
    logic [31:0] r_regs [32];
    logic [31:0] r_pc;
    logic [1:0]  r_alu_op;
    logic [5:0]  r_alu_func;
    logic [31:0] r_alu_in1;
    logic [31:0] r_alu_in2;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_done;
    logic        r_err;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_func;
    logic [31:0] w_sext_imm;
    logic [31:0] w_br_off;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_is_r;
    logic        w_is_addi;
    logic        w_is_beq;
    logic        w_is_shift;
    logic [4:0]  w_dest;
    logic        w_wr_en;

    assign w_opcode   = r_instr[31:26];
    assign w_rs       = r_instr[25:21];
    assign w_rt       = r_instr[20:16];
    assign w_rd       = r_instr[15:11];
    assign w_shamt    = r_instr[10:6];
    assign w_func     = r_instr[5:0];
    assign w_sext_imm = {{16{r_instr[15]}}, r_instr[15:0]};
    assign w_br_off   = w_sext_imm << 2;

    assign w_rs_val   = (w_rs == 5'd0) ? 32'd0 : r_regs[w_rs];
    assign w_rt_val   = (w_rt == 5'd0) ? 32'd0 : r_regs[w_rt];

    assign w_is_r     = (w_opcode == 6'd0);
    assign w_is_addi  = (w_opcode == 6'd8);
    assign w_is_beq   = (w_opcode == 6'd4);
    assign w_is_shift = (w_func == 6'd3) || (w_func == 6'd4);
    assign w_dest     = w_is_r ? w_rd : w_rt;
    assign w_wr_en    = (w_is_r || w_is_addi) && (w_dest != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_instr    <= 32'd0;
            r_pc       <= PC_RESET;
            r_alu_op   <= 2'd0;
            r_alu_func <= 6'd0;
            r_alu_in1  <= 32'd0;
            r_alu_in2  <= 32'd0;
            r_result   <= 32'd0;
            r_zero     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_is_r) begin
                        r_alu_op   <= 2'b10;
                        r_alu_func <= w_func;
                        r_alu_in1  <= w_is_shift ? w_rt_val : w_rs_val;
                        r_alu_in2  <= w_is_shift ? {27'd0, w_shamt} : w_rt_val;
                        r_err      <= 1'b0;
                        r_state    <= S_EXEC;
                    end else if (w_is_addi || w_is_beq) begin
                        r_alu_op   <= w_is_addi ? 2'b00 : 2'b01;
                        r_alu_func <= 6'd0;
                        r_alu_in1  <= w_rs_val;
                        r_alu_in2  <= w_is_addi ? w_sext_imm : w_rt_val;
                        r_err      <= 1'b0;
                        r_state    <= S_EXEC;
                    end else begin
                        // Illegal opcode: retire immediately, leaving the ALU drive untouched.
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_WB;
                    end
                end
                S_EXEC: begin
                    r_result <= alu_out;
                    r_zero   <= alu_zero;
                    r_done   <= 1'b1;
                    r_state  <= S_WB;
                end
                S_WB: begin
                    if (w_wr_en && !r_err) r_regs[w_dest] <= r_result;
                    if (w_is_beq && r_zero) r_pc <= r_pc + 32'd4 + w_br_off;
                    else                    r_pc <= r_pc + 32'd4;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign alu_op      = r_alu_op;
    assign alu_func    = r_alu_func;
    assign alu_in1     = r_alu_in1;
    assign alu_in2     = r_alu_in2;
    assign pc          = r_pc;
    assign done        = r_done;
    assign err         = r_err;
    assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : r_regs[dbg_addr];
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural ALU, a stimulus process that pushes
// expected retirements, and a monitor that checks each done pulse against the queue.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [1:0]  alu_op;
  logic [5:0]  alu_func;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic [31:0] pc;
  logic        done;
  logic        err;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;

  logic [4:0]  mon_addr;
  logic [4:0]  tb_addr;
  logic        mon_own;

  int n_checks;
  int n_fail;

  // Expected retirement: {err, pc after WB, register to inspect, its value}.
  logic [69:0] exp_q[$];

  assign dbg_addr = mon_own ? mon_addr : tb_addr;

  alu_sequencer #(.PC_RESET(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_op      (alu_op),
    .alu_func    (alu_func),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .pc          (pc),
    .done        (done),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .dbg_state   (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural ALU
  always_comb begin
    alu_out = 32'd0;
    case (alu_op)
      2'b00: alu_out = alu_in1 + alu_in2;
      2'b01: alu_out = alu_in1 - alu_in2;
      2'b10: begin
        case (alu_func)
          6'd0: alu_out = alu_in1 + alu_in2;
          6'd1: alu_out = alu_in1 - alu_in2;
          6'd2: alu_out = alu_in1 & alu_in2;
          6'd3: alu_out = alu_in1 << alu_in2[4:0];
          6'd4: alu_out = alu_in1 >> alu_in2[4:0];
          default: alu_out = 32'd0;
        endcase
      end
      default: alu_out = 32'd0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [69:0] mk(input logic e, input logic [31:0] p,
                                     input logic [4:0] a, input logic [31:0] v);
    return {e, p, a, v};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [69:0] e;
        e = exp_q.pop_front();
        chk("err", {31'd0, err}, {31'd0, e[69]});
        mon_addr = e[36:32];
        mon_own  = 1'b1;
        @(negedge clk);
        chk("pc_after_wb", pc, e[68:37]);
        chk("reg_after_wb", dbg_data, e[31:0]);
        mon_own = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Driver: issue one instruction and check ALU drive and done latency.
  task automatic issue(input logic [31:0] ins, input logic illegal,
                       input logic chk_func, input logic [1:0] e_op, input logic [5:0] e_func,
                       input logic [31:0] e_in1, input logic [31:0] e_in2, input logic [69:0] e);
    @(negedge clk);
    wait_ready();
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("alu_op", {30'd0, alu_op}, {30'd0, e_op});
    chk("alu_in1", alu_in1, e_in1);
    chk("alu_in2", alu_in2, e_in2);
    if (chk_func) chk("alu_func", {26'd0, alu_func}, {26'd0, e_func});
    if (illegal) begin
      chk("done_latency_illegal", {31'd0, done}, 32'd1);
    end else begin
      chk("done_early", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("done_latency", {31'd0, done}, 32'd1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_own || !instr_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", exp_q.size(), 32'd0);
  endtask

  initial begin
    int accepts;
    logic [31:0] model_pc;
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    tb_addr     = 5'd0;
    mon_addr    = 5'd0;
    mon_own     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_alu_op", {30'd0, alu_op}, 32'd0);
    chk("rst_alu_func", {26'd0, alu_func}, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    issue(32'h2001000F, 0, 1, 2'b00, 6'd0, 32'd0,  32'd15, mk(0, 32'd4,  5'd1, 32'd15));
    issue(32'h20020018, 0, 1, 2'b00, 6'd0, 32'd0,  32'd24, mk(0, 32'd8,  5'd2, 32'd24));
    issue(32'h00221801, 0, 1, 2'b10, 6'd1, 32'd15, 32'd24, mk(0, 32'd12, 5'd3, 32'hFFFF_FFF7));
    issue(32'h000120C3, 0, 1, 2'b10, 6'd3, 32'd15, 32'd3,  mk(0, 32'd16, 5'd4, 32'd120));
    issue(32'h10210002, 0, 0, 2'b01, 6'd0, 32'd15, 32'd15, mk(0, 32'd28, 5'd1, 32'd15));
    issue(32'h10220002, 0, 0, 2'b01, 6'd0, 32'd15, 32'd24, mk(0, 32'd32, 5'd2, 32'd24));
    issue(32'h1000FFFF, 0, 0, 2'b01, 6'd0, 32'd0,  32'd0,  mk(0, 32'd32, 5'd0, 32'd0));
    issue(32'h2025FFEC, 0, 1, 2'b00, 6'd0, 32'd15, 32'hFFFF_FFEC, mk(0, 32'd36, 5'd5, 32'hFFFF_FFFB));
    issue(32'h00222807, 0, 1, 2'b10, 6'd7, 32'd15, 32'd24, mk(0, 32'd40, 5'd5, 32'd0));
    issue(32'h20000005, 0, 1, 2'b00, 6'd0, 32'd0,  32'd5,  mk(0, 32'd44, 5'd0, 32'd0));
    issue(32'hFC000000, 1, 1, 2'b00, 6'd0, 32'd0,  32'd5,  mk(1, 32'd48, 5'd1, 32'd15));
    drain();

    // instr_valid held high: one accept every 4 cycles
    model_pc = 32'd48;
    accepts  = 0;
    @(negedge clk);
    wait_ready();
    instr       = 32'h20C60001;
    instr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (instr_ready) begin
        accepts++;
        model_pc = model_pc + 32'd4;
        exp_q.push_back(mk(0, model_pc, 5'd6, accepts));
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("accepts_in_16_cycles", accepts, 32'd4);
    drain();

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    wait_ready();
    instr       = 32'h20010063;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_exec_in2", alu_in2, 32'd99);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_pc", pc, 32'd0);
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_alu_in2", alu_in2, 32'd0);
    for (int a = 1; a < 7; a++) begin
      tb_addr = a[4:0];
      #1 chk("abort_reg_zero", dbg_data, 32'd0);
    end
    repeat (6) @(negedge clk);
    chk("abort_pc_stable", pc, 32'd0);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
